// File: rtl/tx_hs_pkg.sv
// Shared D-PHY HS transmit definitions: HS FSM state codes, SYNC byte, feeder types.
package tx_hs_pkg;

  localparam int unsigned HS_STATE_W = 3;
  localparam int unsigned BYTE_W     = 8;

  typedef enum logic [HS_STATE_W-1:0] {
    HS_STOP  = 3'd0,
    HS_ZERO  = 3'd1,
    HS_SYNC  = 3'd2,
    HS_DATA  = 3'd3,
    HS_TRAIL = 3'd4
  } hs_state_e;

  localparam logic [BYTE_W-1:0] HS_SYNC_BYTE = 8'h1D;

  typedef enum logic [1:0] {
    FD_IDLE   = 2'd0,
    FD_ACTIVE = 2'd1,
    FD_DRAIN  = 2'd2
  } feed_state_e;

  // One buffered byte with its end-of-packet marker.
  typedef struct packed {
    logic              last;
    logic [BYTE_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/tx_hs_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head entry is always visible on dout.
module tx_hs_sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 9
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage array; contents survive reset, only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tx_hs_byte_feeder.sv
// Packet-aware byte buffer feeding the HS transmit FSM of one D-PHY TX lane.
module tx_hs_byte_feeder
  import tx_hs_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned T_LP_GAP   = 2
) (
  input  logic       TX_DDR_clk,
  input  logic       TX_rst_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  input  logic [2:0] TX_HS_STATE,
  input  logic       TX_HS_READY,
  output logic       Enable,
  output logic [7:0] TX_BYTE_DATA,
  output logic       TX_HS_END_DATA,
  output logic       underrun_err,
  output logic       busy
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned GW = $clog2(T_LP_GAP + 2);
  localparam int unsigned EW = $bits(fifo_entry_t);

  feed_state_e   state;
  logic [GW-1:0] gap_cnt;
  logic [CW-1:0] pkt_cnt;
  logic [CW-1:0] fifo_count;
  fifo_entry_t   din;
  fifo_entry_t   head;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          active;
  logic          hs_stop;
  logic          underrun_c;
  logic          pkt_in_c;
  logic          pkt_out_c;

  assign din        = '{last: s_last, data: s_data};
  assign push       = s_valid & ~full;
  assign active     = (state == FD_ACTIVE);
  assign hs_stop    = (TX_HS_STATE == HS_STOP);
  assign pop        = TX_HS_READY & active & ~empty;
  assign underrun_c = TX_HS_READY & active & empty;
  assign pkt_in_c   = push & s_last;
  assign pkt_out_c  = pop & head.last;

  assign s_ready        = ~full;
  assign busy           = (state != FD_IDLE);
  assign Enable         = active | ((state == FD_DRAIN) & ~hs_stop);
  assign TX_BYTE_DATA   = empty ? 8'h00 : head.data;
  assign TX_HS_END_DATA = TX_HS_READY & active & (empty | head.last);

  tx_hs_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (TX_DDR_clk),
    .rst_n (TX_rst_n),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // Feeder FSM: start on a whole packet or a full buffer, drain until the HS FSM is back in STOP.
  always_ff @(posedge TX_DDR_clk) begin
    if (!TX_rst_n) begin
      state   <= FD_IDLE;
      gap_cnt <= GW'(T_LP_GAP);
    end else begin
      case (state)
        FD_IDLE: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GW'(1);
          end else if ((pkt_cnt != '0) || (fifo_count == CW'(FIFO_DEPTH))) begin
            state <= FD_ACTIVE;
          end
        end
        FD_ACTIVE: begin
          if (TX_HS_END_DATA) state <= FD_DRAIN;
        end
        FD_DRAIN: begin
          if (hs_stop) begin
            state   <= FD_IDLE;
            gap_cnt <= GW'(T_LP_GAP);
          end
        end
        default: state <= FD_IDLE;
      endcase
    end
  end

  // Number of complete packets held in the buffer.
  always_ff @(posedge TX_DDR_clk) begin
    if (!TX_rst_n) begin
      pkt_cnt <= '0;
    end else begin
      case ({pkt_in_c, pkt_out_c})
        2'b10:   pkt_cnt <= pkt_cnt + CW'(1);
        2'b01:   pkt_cnt <= pkt_cnt - CW'(1);
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  // Sticky underrun flag; only reset clears it.
  always_ff @(posedge TX_DDR_clk) begin
    if (!TX_rst_n) begin
      underrun_err <= 1'b0;
    end else if (underrun_c) begin
      underrun_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tx_hs_byte_feeder.sv
// Directed bench for tx_hs_byte_feeder with a behavioural HS transmit FSM attached.
module tb_tx_hs_byte_feeder;
  import tx_hs_pkg::*;

  logic       TX_DDR_clk = 1'b0;
  logic       TX_rst_n   = 1'b0;
  logic [7:0] s_data     = 8'h00;
  logic       s_valid    = 1'b0;
  logic       s_last     = 1'b0;
  logic       s_ready;
  logic [2:0] TX_HS_STATE;
  logic       TX_HS_READY;
  logic       Enable;
  logic [7:0] TX_BYTE_DATA;
  logic       TX_HS_END_DATA;
  logic       underrun_err;
  logic       busy;

  int n_checks = 0;
  int n_err    = 0;

  tx_hs_byte_feeder #(
    .FIFO_DEPTH (16),
    .T_LP_GAP   (2)
  ) dut (
    .TX_DDR_clk     (TX_DDR_clk),
    .TX_rst_n       (TX_rst_n),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_last         (s_last),
    .s_ready        (s_ready),
    .TX_HS_STATE    (TX_HS_STATE),
    .TX_HS_READY    (TX_HS_READY),
    .Enable         (Enable),
    .TX_BYTE_DATA   (TX_BYTE_DATA),
    .TX_HS_END_DATA (TX_HS_END_DATA),
    .underrun_err   (underrun_err),
    .busy           (busy)
  );

  always #5 TX_DDR_clk = ~TX_DDR_clk;

  // Edge index: after posedge k the value is k.
  int cyc = 0;
  always @(posedge TX_DDR_clk) cyc <= cyc + 1;

  // Behavioural HS FSM: 4 ZERO, 1 SYNC, DATA until END_DATA, 4 TRAIL; aborts to STOP if Enable drops.
  hs_state_e  hs_state = HS_STOP;
  logic [1:0] hs_cnt   = 2'd0;
  assign TX_HS_STATE = hs_state;
  assign TX_HS_READY = (hs_state == HS_DATA);

  always @(posedge TX_DDR_clk) begin
    case (hs_state)
      HS_STOP:  if (Enable) begin hs_state <= HS_ZERO; hs_cnt <= 2'd0; end
      HS_ZERO:  if (!Enable) hs_state <= HS_STOP;
                else if (hs_cnt == 2'd3) hs_state <= HS_SYNC;
                else hs_cnt <= hs_cnt + 2'd1;
      HS_SYNC:  hs_state <= Enable ? HS_DATA : HS_STOP;
      HS_DATA:  if (!Enable) hs_state <= HS_STOP;
                else if (TX_HS_END_DATA) begin hs_state <= HS_TRAIL; hs_cnt <= 2'd0; end
      HS_TRAIL: if (hs_cnt == 2'd3) hs_state <= HS_STOP;
                else hs_cnt <= hs_cnt + 2'd1;
      default:  hs_state <= HS_STOP;
    endcase
  end

  // Monitor: transmitted bytes {end, data}, Enable edges, ZERO entries, Enable still high on return to STOP.
  logic [8:0] txq[$];
  hs_state_e  prev_hs      = HS_STOP;
  logic       prev_en      = 1'b0;
  int         en_rise_cyc  = 0;
  int         en_fall_cyc  = 0;
  int         last_gap     = 0;
  int         zero_n       = 0;
  int         stop_viol    = 0;

  always @(negedge TX_DDR_clk) begin
    if (TX_HS_READY && Enable) txq.push_back({TX_HS_END_DATA, TX_BYTE_DATA});
    if (Enable && !prev_en) begin
      en_rise_cyc <= cyc;
      last_gap    <= cyc - en_fall_cyc;
    end
    if (!Enable && prev_en) en_fall_cyc <= cyc;
    if (hs_state == HS_ZERO && prev_hs == HS_STOP) zero_n <= zero_n + 1;
    if (hs_state == HS_STOP && prev_hs == HS_TRAIL && Enable) stop_viol <= stop_viol + 1;
    prev_hs <= hs_state;
    prev_en <= Enable;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge TX_DDR_clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d, input logic l);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (!TX_HS_END_DATA && n < 300) begin step(); n++; end
    check(tag, 32'(TX_HS_END_DATA), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 300) begin step(); n++; end
    check(tag, 32'(busy), 32'd0);
  endtask

  int e;
  int base;
  int z0;
  int n0;

  initial begin
    // Reset state
    TX_rst_n = 1'b0;
    step(); step(); step();
    check("rst_enable",  32'(Enable),         32'd0);
    check("rst_s_ready", 32'(s_ready),        32'd1);
    check("rst_end",     32'(TX_HS_END_DATA), 32'd0);
    check("rst_data",    32'(TX_BYTE_DATA),   32'h00);
    check("rst_busy",    32'(busy),           32'd0);
    check("rst_underr",  32'(underrun_err),   32'd0);
    TX_rst_n = 1'b1;
    step(); step(); step(); step();

    // 3-byte packet A1 A2 A3
    base = txq.size();
    z0   = zero_n;
    push_byte(8'hA1, 1'b0);
    push_byte(8'hA2, 1'b0);
    push_byte(8'hA3, 1'b1);
    e = cyc;
    check("t1_pkt_cnt", 32'(dut.pkt_cnt), 32'd1);
    wait_end("t1_end_seen");
    check("t1_end_cyc", 32'(cyc), 32'(e + 9));
    step();
    wait_idle("t1_idle");
    check("t1_nbytes",  32'(txq.size() - base), 32'd3);
    check("t1_b0",      32'(txq[base]),     32'h0A1);
    check("t1_b1",      32'(txq[base + 1]), 32'h0A2);
    check("t1_b2",      32'(txq[base + 2]), 32'h1A3);
    check("t1_rise",    32'(en_rise_cyc),   32'(e + 1));
    check("t1_fall",    32'(en_fall_cyc),   32'(e + 14));
    check("t1_zero_n",  32'(zero_n - z0),   32'd1);
    check("t1_stop_en", 32'(stop_viol),     32'd0);
    step(); step(); step(); step();

    // Two back-to-back 2-byte packets
    base = txq.size();
    z0   = zero_n;
    push_byte(8'hB1, 1'b0);
    push_byte(8'hB2, 1'b1);
    push_byte(8'hC1, 1'b0);
    push_byte(8'hC2, 1'b1);
    check("t2_pkt_2", 32'(dut.pkt_cnt), 32'd2);
    wait_end("t2_end1");
    step();
    check("t2_pkt_1", 32'(dut.pkt_cnt), 32'd1);
    wait_end("t2_end2");
    step();
    check("t2_pkt_0", 32'(dut.pkt_cnt), 32'd0);
    wait_idle("t2_idle");
    check("t2_zero_n", 32'(zero_n - z0), 32'd2);
    check("t2_nbytes", 32'(txq.size() - base), 32'd4);
    check("t2_b1",     32'(txq[base + 1]), 32'h1B2);
    check("t2_b2",     32'(txq[base + 2]), 32'h0C1);
    check("t2_b3",     32'(txq[base + 3]), 32'h1C2);
    check("t2_gap_ok", 32'(last_gap >= 3), 32'd1);
    check("t2_stop_en", 32'(stop_viol),    32'd0);
    step(); step(); step(); step();

    // Cut-through on full buffer, then upstream stalls
    base = txq.size();
    for (int i = 0; i < 16; i++) push_byte(8'(8'h10 + i), 1'b0);
    check("t3_s_ready", 32'(s_ready), 32'd0);
    check("t3_count",   32'(dut.fifo_count), 32'd16);
    step();
    check("t3_enable",  32'(Enable), 32'd1);
    wait_end("t3_end");
    check("t3_pad",     32'(TX_BYTE_DATA), 32'h00);
    step();
    wait_idle("t3_idle");
    check("t3_nbytes",  32'(txq.size() - base), 32'd17);
    check("t3_b0",      32'(txq[base]),      32'h010);
    check("t3_b15",     32'(txq[base + 15]), 32'h01F);
    check("t3_b16",     32'(txq[base + 16]), 32'h100);
    check("t3_underr",  32'(underrun_err), 32'd1);
    step(); step(); step(); step();
    check("t3_sticky",  32'(underrun_err), 32'd1);

    // Push of a last byte in the same cycle as the pop of a last byte
    base = txq.size();
    push_byte(8'hD1, 1'b0);
    push_byte(8'hD2, 1'b1);
    wait_end("t4_end");
    check("t4_pre_pkt",   32'(dut.pkt_cnt),    32'd1);
    check("t4_pre_count", 32'(dut.fifo_count), 32'd1);
    push_byte(8'hE1, 1'b1);
    check("t4_pkt",   32'(dut.pkt_cnt),    32'd1);
    check("t4_count", 32'(dut.fifo_count), 32'd1);
    wait_idle("t4_idle1");
    wait_end("t4_end2");
    step();
    wait_idle("t4_idle2");
    check("t4_nbytes", 32'(txq.size() - base), 32'd3);
    check("t4_b1",     32'(txq[base + 1]), 32'h1D2);
    check("t4_b2",     32'(txq[base + 2]), 32'h1E1);
    check("t4_underr", 32'(underrun_err), 32'd1);
    step(); step(); step(); step();

    // Reset pulse during DATA of a 10-byte packet
    base = txq.size();
    for (int i = 0; i < 10; i++) push_byte(8'(8'h50 + i), i == 9);
    begin
      int n = 0;
      while ((txq.size() - base) < 3 && n < 300) begin step(); n++; end
    end
    check("t5_mid_data", 32'(TX_HS_READY), 32'd1);
    TX_rst_n = 1'b0;
    step();
    TX_rst_n = 1'b1;
    check("t5_enable",  32'(Enable),       32'd0);
    check("t5_s_ready", 32'(s_ready),      32'd1);
    check("t5_data",    32'(TX_BYTE_DATA), 32'h00);
    check("t5_busy",    32'(busy),         32'd0);
    check("t5_underr",  32'(underrun_err), 32'd0);
    n0 = txq.size();
    z0 = zero_n;
    for (int i = 0; i < 40; i++) step();
    check("t5_no_bytes", 32'(txq.size() - n0), 32'd0);
    check("t5_no_zero",  32'(zero_n - z0),     32'd0);
    check("t5_hs_stop",  32'(hs_state),        32'(HS_STOP));
    check("t5_still_idle", 32'(busy),          32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/tx_hs_byte_feeder.md
# tx_hs_byte_feeder

Packet-aware byte buffer that sits directly upstream of the HS transmit FSM for one D-PHY TX lane. It accepts a valid/ready byte stream with end-of-packet marking and raises the HS request (Enable) only when a whole packet is buffered, or the buffer is full. It then supplies one byte per cycle while the FSM reports HS-ready, flags the last byte with TX_HS_END_DATA, and holds Enable until the FSM has finished its trail and returned to STOP.

## Interface
- FIFO_DEPTH, 16: byte entries (power of 2, ≥4); max packet length that is guaranteed underrun-free.
- T_LP_GAP, 2: minimum cycles in IDLE after a burst before Enable may rise again.
- TX_DDR_clk  in  1  byte clock; the only clock.
- TX_rst_n  in  1  reset, synchronous, active-low.
- s_data  in  8  upstream byte.
- s_valid  in  1  upstream byte valid.
- s_last  in  1  byte is the last of its packet.
- s_ready  out  1  `!full`.
- TX_HS_STATE  in  3  HS FSM state: STOP=0, ZERO=1, SYNC=2, DATA=3, TRAIL=4.
- TX_HS_READY  in  1  HS FSM is consuming TX_BYTE_DATA this cycle.
- Enable  out  1  HS request to the FSM.
- TX_BYTE_DATA  out  8  FIFO head byte; 8'h00 when the FIFO is empty.
- TX_HS_END_DATA  out  1  current byte is the last of the burst.
- underrun_err  out  1  sticky; cleared only by reset.
- busy  out  1  feeder state ≠ IDLE.

## Operation
- Reset (TX_rst_n=0 at an edge) sets the following: pointers, count and pkt_cnt = 0, feeder state IDLE, gap_cnt = T_LP_GAP, underrun_err = 0.
- Resulting reset output values: Enable 0, s_ready 1, TX_HS_END_DATA 0, TX_BYTE_DATA 8'h00, busy 0.
- FIFO contents are not reset.
- FIFO behaviour:
  - First-word-fall-through; each entry holds 9 bits {last, data}.
  - Push = s_valid & s_ready.
  - Pop = TX_HS_READY & (state == ACTIVE) & !empty.
  - Push and pop in the same cycle are allowed at any fill level, including full (no push) and empty (no pop).
  - Count width is clog2(FIFO_DEPTH)+1.
- pkt_cnt:
  - +1 on a push with s_last.
  - −1 on a pop of an entry with last set.
  - Both in the same cycle: unchanged.
- Feeder FSM states IDLE, ACTIVE, DRAIN:
  - IDLE → ACTIVE when gap_cnt == 0 and (pkt_cnt > 0 or full). gap_cnt decrements to 0 while in IDLE.
  - ACTIVE → DRAIN when the popped byte has last set, or on underrun.
  - DRAIN → IDLE when TX_HS_STATE == STOP. gap_cnt reloads to T_LP_GAP at this transition.
- Enable is combinational: (state == ACTIVE) | (state == DRAIN & TX_HS_STATE ≠ STOP). It therefore drops in the same cycle the FSM returns to STOP, so the FSM cannot re-enter ZERO.
- TX_HS_END_DATA is combinational:
  - TX_HS_READY & (state == ACTIVE) & ((!empty & head.last) | empty).
  - It is never asserted outside DATA.
- Underrun = TX_HS_READY & ACTIVE & empty. On underrun:
  - TX_BYTE_DATA = 8'h00 (pad byte) and TX_HS_END_DATA = 1.
  - underrun_err is set; the burst ends normally.
- Cut-through case: a burst started because the FIFO was full, with no last byte yet, streams while upstream keeps refilling. It can underrun.
- A packet longer than FIFO_DEPTH is legal, but is underrun-free only if upstream sustains 1 byte/cycle.

## Timing
- Complete packet of N bytes, last byte pushed at edge e, gap already expired:
  - ACTIVE / Enable=1 during cycle e+1.
  - FSM in ZERO during e+2..e+5, SYNC at e+6.
  - DATA during e+7..e+6+N; byte k is popped in cycle e+6+k.
  - TX_HS_END_DATA is high in cycle e+6+N only.
  - TRAIL during e+7+N..e+10+N; STOP at e+11+N, when Enable drops combinationally.
  - IDLE from e+12+N; the next Enable rises no earlier than e+12+N+T_LP_GAP.
- Zero combinational paths from s_* to Enable, TX_BYTE_DATA or TX_HS_END_DATA. All three derive from registers, TX_HS_STATE and TX_HS_READY only.
- Reset asserted mid-burst: Enable drops at the next edge and the FIFO is flushed. The HS FSM returns to STOP because Enable is low.

## Structure
- Package tx_hs_pkg holds the HS state codes (STOP…TRAIL, 3 bits) and the SYNC byte 8'h1D. These are shared with the HS FSM.
- Sub-module tx_hs_sync_fifo:
  - Parameterised 9-bit FWFT FIFO, single clock, synchronous active-low reset.
  - Ports: push, pop, din, dout, full, empty, count.
- The feeder FSM, pkt_cnt, gap_cnt and underrun logic live in the top module.

## Test plan
- 3-byte packet A1 A2 A3 (last on A3) into an idle block, with the HS FSM model attached:
  - Bytes appear on TX_BYTE_DATA in DATA order A1, A2, A3.
  - END_DATA only with A3.
  - Enable low in the cycle TX_HS_STATE returns to 0, and no second ZERO entry.
- Two back-to-back 2-byte packets written before the first burst:
  - Two separate bursts.
  - Idle gap between Enable fall and rise ≥ T_LP_GAP+1 cycles.
  - pkt_cnt goes 2→1→0.
- FIFO_DEPTH=16 with 16 bytes pushed and no last: s_ready=0 and Enable rises (cut-through). Then stop upstream; required response:
  - Byte 17 slot outputs 00 with END_DATA=1.
  - underrun_err=1 and stays high.
- Simultaneous push of a last byte and pop of a last byte: pkt_cnt unchanged, count unchanged.
- Reset held low for 1 cycle during DATA of a 10-byte packet:
  - Next cycle Enable=0, s_ready=1, TX_BYTE_DATA=00, busy=0.
  - No further bytes are transmitted.
